anton_neopixel_stream_sequencer: RTL and testbench
==================================================

# anton_neopixel_stream_sequencer

Frame sequencer that walks the NeoPixel pixel buffer held by the register block and serialises it onto the single-wire `neoData` output. It takes the control bits (`regMax`, `regCtrlRun`, `regCtrlLimit`, `regCtrl32bit`, `regCtrlInit`) from the register block, reads pixel bytes through a combinational address/data port, and generates WS2812-style bit timing followed by the latch gap. It reports end-of-frame with `streamSyncOf`, which the register block uses to reload `regCtrlRun` from `regCtrlLoop`.

## Interface
- `BUFFER_END`, `` `BUFFER_END_DEFAULT ``: highest valid pixel-buffer byte address.
- `CYCLES_PER_BIT`, 8: `busClk` cycles per data bit; must be ≥ 4.
- `T0H_CYCLES`, 2: high cycles for a 0 bit; must be ≥ 1 and < `T1H_CYCLES`.
- `T1H_CYCLES`, 5: high cycles for a 1 bit; must be < `CYCLES_PER_BIT`.
- `RESET_CYCLES`, 384: low cycles of the latch gap; must be ≥ 2.

Ports:
- `busClk` in 1: sole clock. All logic is on the rising edge.
- `busRstN` in 1: reset, asynchronous, active-low.
- `regMax` in 13: last byte address when the limit is enabled.
- `regCtrlRun` in 1: start request. Sampled only in IDLE.
- `regCtrlLimit` in 1: 1 means the frame ends at `regMax`; 0 means it ends at `BUFFER_END`.
- `regCtrl32bit` in 1: 1 means every byte with address[1:0]==3 is a padding byte and is not sent.
- `regCtrlInit` in 1: synchronous abort.
- `pixelAddr` out 13: registered read address into the pixel buffer.
- `pixelByte` in 8: buffer byte at `pixelAddr`. Combinational; valid in the same cycle as the address.
- `neoData` out 1: serial output to the LED chain.
- `streamSyncOf` out 1: one-cycle pulse at the end of a frame.
- `state` out 1: 1 while a frame is in progress (any state other than IDLE).

## Operation
- FSM states: IDLE, BIT, GAP.
- **End address:** `endAddr = regCtrlLimit ? min(regMax, BUFFER_END) : BUFFER_END`. It is latched on leaving IDLE and ignored for the rest of the frame.
- **IDLE:**
  - `neoData`=0, `pixelAddr`=0.
  - If `regCtrlRun`=1 and `regCtrlInit`=0: load the shift register from `pixelByte` (address 0), set bitIdx=7 and bitCnt=0, then go to BIT.
- **BIT:**
  - `neoData` = 1 while bitCnt < (shift[7] ? `T1H_CYCLES` : `T0H_CYCLES`), else 0.
  - Bits are sent MSB first.
  - When bitCnt == `CYCLES_PER_BIT`-1: bitCnt goes to 0 and the shift register shifts left.
  - When bitIdx reaches 0: if `nextAddr` ≤ `endAddr`, load the shift register from `pixelByte` (already at `nextAddr`) and set bitIdx=7; otherwise go to GAP.
- **Prefetch:** `pixelAddr` is updated to `nextAddr` at the first cycle of bit 3 of the current byte.
  - `nextAddr` = addr+1.
  - With 32-bit mode active and (addr+1)[1:0]==3, `nextAddr` = addr+2 instead.
  - The adder is 14 bits wide, so it cannot wrap.
- **GAP:**
  - `neoData`=0 for `RESET_CYCLES` cycles.
  - `streamSyncOf`=1 on the last GAP cycle only.
  - The FSM then goes to IDLE.
- **Run and loop:**
  - `regCtrlRun` dropping mid-frame does not stop the frame; the frame finishes.
  - Looping is solely the register block's reload of `regCtrlRun` on `streamSyncOf`.
- **Abort:** `regCtrlInit`=1 in any state forces IDLE on the next edge.
  - `neoData`=0 and `pixelAddr`=0.
  - No `streamSyncOf` pulse is emitted.
  - The FSM stays in IDLE while `regCtrlInit`=1.
- **Boundaries:**
  - `regMax`=0 with the limit on sends exactly 1 byte.
  - `regMax` > `BUFFER_END` is clamped to `BUFFER_END`.
  - In 32-bit mode, a padding `endAddr` ends the frame after the preceding byte.
- **Reset values:** FSM=IDLE, `neoData`=0, `streamSyncOf`=0, `state`=0, `pixelAddr`=0, counters=0, shift register=0.

## Timing
- **Start:** `regCtrlRun`=1 sampled in IDLE at cycle T → `neoData` high at T+1. A frame always starts with a high pulse.
- **Frame length:** N transmitted bytes → BIT lasts N×8×`CYCLES_PER_BIT` cycles. GAP follows immediately with no idle cycle between bytes.
- **Sync:** `streamSyncOf` is high in cycle S, IDLE is entered at S+1, and `regCtrlRun` (already reloaded) is sampled there. If it is 1, the next frame starts at S+2.
- **Buffer read:** the buffer must hold `pixelByte` stable for the address presented. The prefetch gives ≥4 bit periods of settling before the byte is loaded.
- **Reset:** `busRstN` low at any time clears all outputs asynchronously. The release is synchronous to `busClk`.

## Configuration
- `ANTON_SEQ_32BIT_EN` defined: `regCtrl32bit` enables padding-byte skipping as described.
- `ANTON_SEQ_32BIT_EN` undefined: `regCtrl32bit` is ignored and the skip logic is not compiled. Every address from 0 to `endAddr` is sent.

## Test plan
- **Basic frame.** Setup: defaults, limit=1, `regMax`=2, bytes 0xA5,0x0F,0x80, run pulsed.
  - 24 bit periods with high widths of 5/2 cycles matching the bits.
  - Then 384 low cycles.
  - `streamSyncOf` is a single pulse at cycle 24×8+384 after the first high cycle.
- **32-bit skip.** Setup: `ANTON_SEQ_32BIT_EN` defined, 32bit=1, `regMax`=7.
  - Addresses 0,1,2,4,5,6 are sent (48 bits).
  - Bytes at 3 and 7 are never shifted out.
  - With the macro undefined: 64 bits.
- **Loop.** Setup: `regCtrlRun` is held at 1 by the model's reload.
  - `neoData` rises 2 cycles after `streamSyncOf`.
  - Three consecutive frames have identical waveforms.
- **Abort.** Setup: `regCtrlInit` pulsed in bit 5 of byte 1.
  - Next cycle: `neoData`=0, `state`=0, `pixelAddr`=0.
  - No `streamSyncOf`; no restart while init=1.
- **Reset mid-GAP.** Setup: `busRstN` low for 1 cycle during GAP.
  - All outputs reach reset values asynchronously.
  - No `streamSyncOf`.
  - A new frame starts from address 0 after release.
- **Limit edge.** Setup: limit=1, `regMax`=0x1FFF (> `BUFFER_END`).
  - The frame ends after byte `BUFFER_END`.
  - `regMax`=0 sends exactly 8 bits.

Source files
------------

// File: rtl/anton_neopixel_stream_sequencer.sv
// NeoPixel frame sequencer: walks the pixel buffer and serialises it with WS2812 bit timing plus latch gap.
// Define ANTON_SEQ_32BIT_EN to compile in padding-byte skipping driven by regCtrl32bit.

`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 13'd2047
`endif

module anton_neopixel_stream_sequencer #(
    parameter logic [12:0] BUFFER_END     = `BUFFER_END_DEFAULT,
    parameter int unsigned CYCLES_PER_BIT = 8,
    parameter int unsigned T0H_CYCLES     = 2,
    parameter int unsigned T1H_CYCLES     = 5,
    parameter int unsigned RESET_CYCLES   = 384
) (
    input  logic        busClk,
    input  logic        busRstN,
    input  logic [12:0] regMax,
    input  logic        regCtrlRun,
    input  logic        regCtrlLimit,
    input  logic        regCtrl32bit,
    input  logic        regCtrlInit,
    output logic [12:0] pixelAddr,
    input  logic [7:0]  pixelByte,
    output logic        neoData,
    output logic        streamSyncOf,
    output logic        state
);

    localparam int unsigned BitCntW = $clog2(CYCLES_PER_BIT);
    localparam int unsigned GapCntW = $clog2(RESET_CYCLES);
    localparam logic [BitCntW-1:0] LastBitCnt = BitCntW'(CYCLES_PER_BIT - 1);
    localparam logic [GapCntW-1:0] LastGapCnt = GapCntW'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BIT,
        GAP
    } seqStateT;

    seqStateT          curState, stateNext;
    logic [7:0]        shiftReg, shiftNext;
    logic [2:0]        bitIdx, bitIdxNext;
    logic [BitCntW-1:0] bitCnt, bitCntNext;
    logic [GapCntW-1:0] gapCnt, gapCntNext;
    logic [13:0]       fetchAddr, fetchNext;
    logic [12:0]       endAddr, endNext;
    logic [12:0]       limitEnd;
    logic [13:0]       addrInc, nextAddr;
    logic              neoDataNext, syncNext;

    assign pixelAddr = fetchAddr[12:0];
    assign limitEnd  = (regCtrlLimit && (regMax < BUFFER_END)) ? regMax : BUFFER_END;
    assign addrInc   = fetchAddr + 14'd1;

`ifdef ANTON_SEQ_32BIT_EN
    // Byte 3 of every 32-bit word is padding and is stepped over.
    assign nextAddr = (regCtrl32bit && (addrInc[1:0] == 2'd3)) ? (fetchAddr + 14'd2) : addrInc;
`else
    logic unused32bit;
    assign unused32bit = regCtrl32bit;
    assign nextAddr    = addrInc;
`endif

    // Next-state, datapath and output decode
    always_comb begin
        stateNext  = curState;
        shiftNext  = shiftReg;
        bitIdxNext = bitIdx;
        bitCntNext = bitCnt;
        gapCntNext = gapCnt;
        fetchNext  = fetchAddr;
        endNext    = endAddr;

        unique case (curState)
            IDLE: begin
                fetchNext = '0;
                if (regCtrlRun && !regCtrlInit) begin
                    stateNext  = BIT;
                    shiftNext  = pixelByte;
                    bitIdxNext = 3'd7;
                    bitCntNext = '0;
                    endNext    = limitEnd;
                end
            end
            BIT: begin
                if (bitCnt == LastBitCnt) begin
                    bitCntNext = '0;
                    // Prefetch lands on the first cycle of bit 3, leaving 4 bit periods to settle.
                    if (bitIdx == 3'd4) begin
                        fetchNext = nextAddr;
                    end
                    if (bitIdx == 3'd0) begin
                        if (fetchAddr <= {1'b0, endAddr}) begin
                            shiftNext  = pixelByte;
                            bitIdxNext = 3'd7;
                        end else begin
                            stateNext  = GAP;
                            gapCntNext = '0;
                            fetchNext  = '0;
                        end
                    end else begin
                        shiftNext  = {shiftReg[6:0], 1'b0};
                        bitIdxNext = bitIdx - 3'd1;
                    end
                end else begin
                    bitCntNext = bitCnt + BitCntW'(1);
                end
            end
            GAP: begin
                if (gapCnt == LastGapCnt) begin
                    stateNext = IDLE;
                end else begin
                    gapCntNext = gapCnt + GapCntW'(1);
                end
            end
            default: stateNext = IDLE;
        endcase

        if (regCtrlInit) begin
            stateNext = IDLE;
            fetchNext = '0;
        end

        neoDataNext = (stateNext == BIT) &&
                      (32'(bitCntNext) < (shiftNext[7] ? T1H_CYCLES : T0H_CYCLES));
        syncNext    = (stateNext == GAP) && (gapCntNext == LastGapCnt);
    end

    // State and output registers
    always_ff @(posedge busClk or negedge busRstN) begin
        if (!busRstN) begin
            curState     <= IDLE;
            shiftReg     <= '0;
            bitIdx       <= '0;
            bitCnt       <= '0;
            gapCnt       <= '0;
            fetchAddr    <= '0;
            endAddr      <= '0;
            neoData      <= 1'b0;
            streamSyncOf <= 1'b0;
            state        <= 1'b0;
        end else begin
            curState     <= stateNext;
            shiftReg     <= shiftNext;
            bitIdx       <= bitIdxNext;
            bitCnt       <= bitCntNext;
            gapCnt       <= gapCntNext;
            fetchAddr    <= fetchNext;
            endAddr      <= endNext;
            neoData      <= neoDataNext;
            streamSyncOf <= syncNext;
            state        <= (stateNext != IDLE);
        end
    end

endmodule

// File: tb/tb_anton_neopixel_stream_sequencer.sv
// Self-checking bench for anton_neopixel_stream_sequencer: random frames against a waveform model
// built from the buffer contents, plus abort, mid-gap reset, loop and limit-edge scenarios.

module tb_anton_neopixel_stream_sequencer;

    localparam logic [12:0] BE  = 13'd15;
    localparam int          CPB = 8;
    localparam int          T0H = 2;
    localparam int          T1H = 5;
    localparam int          RST = 384;

    logic        busClk = 1'b0;
    logic        busRstN;
    logic [12:0] regMax;
    logic        regCtrlRun;
    logic        regCtrlLimit;
    logic        regCtrl32bit;
    logic        regCtrlInit;
    logic [12:0] pixelAddr;
    logic [7:0]  pixelByte;
    logic        neoData;
    logic        streamSyncOf;
    logic        state;

    logic [7:0]  mem [16];
    bit          expQ [$];
    int          checks = 0;
    int          errors = 0;

    always #5 busClk = ~busClk;

    assign pixelByte = (pixelAddr <= BE) ? mem[pixelAddr[3:0]] : 8'h00;

    anton_neopixel_stream_sequencer #(
        .BUFFER_END    (BE),
        .CYCLES_PER_BIT(CPB),
        .T0H_CYCLES    (T0H),
        .T1H_CYCLES    (T1H),
        .RESET_CYCLES  (RST)
    ) dut (
        .busClk      (busClk),
        .busRstN     (busRstN),
        .regMax      (regMax),
        .regCtrlRun  (regCtrlRun),
        .regCtrlLimit(regCtrlLimit),
        .regCtrl32bit(regCtrl32bit),
        .regCtrlInit (regCtrlInit),
        .pixelAddr   (pixelAddr),
        .pixelByte   (pixelByte),
        .neoData     (neoData),
        .streamSyncOf(streamSyncOf),
        .state       (state)
    );

    task automatic checkValue(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected line waveform: every sent byte MSB first, then the latch gap.
    function automatic void buildExpected();
        int endA;
        bit skip;
        expQ.delete();
        endA = regCtrlLimit ? ((int'(regMax) < int'(BE)) ? int'(regMax) : int'(BE)) : int'(BE);
`ifdef ANTON_SEQ_32BIT_EN
        skip = regCtrl32bit;
`else
        skip = 1'b0;
`endif
        for (int a = 0; a <= endA; a++) begin
            if (skip && (a % 4 == 3)) continue;
            for (int b = 7; b >= 0; b--)
                for (int c = 0; c < CPB; c++)
                    expQ.push_back(c < (mem[a][b] ? T1H : T0H));
        end
        for (int c = 0; c < RST; c++) expQ.push_back(1'b0);
    endfunction

    // Called at a negedge in IDLE (pulse=1) or at the idle cycle after a sync with run held (pulse=0).
    task automatic runFrame(input string tag, input bit pulse, input bit keepRun, output int rises);
        int  waveErr = 0;
        int  stateErr = 0;
        int  syncCnt = 0;
        int  syncAt = -1;
        int  len;
        bit  prev = 1'b0;
        rises = 0;
        buildExpected();
        len = expQ.size();
        if (pulse) begin
            regCtrlRun = 1'b1;
            @(negedge busClk);
            regCtrlRun = keepRun;
        end else begin
            @(negedge busClk);
        end
        for (int i = 0; i < len; i++) begin
            if (neoData !== expQ[i]) waveErr++;
            if (state !== 1'b1) stateErr++;
            if (streamSyncOf === 1'b1) begin
                syncCnt++;
                syncAt = i;
            end
            if (neoData === 1'b1 && !prev) rises++;
            prev = (neoData === 1'b1);
            @(negedge busClk);
        end
        regCtrlRun = keepRun;
        checkValue({tag, " waveform"}, waveErr, 0);
        checkValue({tag, " busy"}, stateErr, 0);
        checkValue({tag, " bits"}, rises, (len - RST) / CPB);
        checkValue({tag, " syncCount"}, syncCnt, 1);
        checkValue({tag, " syncPos"}, syncAt, len - 1);
        checkValue({tag, " idleAfter"}, 32'({state, neoData, streamSyncOf}), 0);
        checkValue({tag, " idleAddr"}, 32'(pixelAddr), 0);
    endtask

    initial begin
        int rises;
        int bad;
        busRstN      = 1'b0;
        regMax       = '0;
        regCtrlRun   = 1'b0;
        regCtrlLimit = 1'b0;
        regCtrl32bit = 1'b0;
        regCtrlInit  = 1'b0;
        foreach (mem[j]) mem[j] = 8'h00;

        repeat (3) @(negedge busClk);
        checkValue("reset neoData", 32'(neoData), 0);
        checkValue("reset sync", 32'(streamSyncOf), 0);
        checkValue("reset state", 32'(state), 0);
        checkValue("reset pixelAddr", 32'(pixelAddr), 0);
        busRstN = 1'b1;
        repeat (2) @(negedge busClk);

        // Basic frame
        mem[0] = 8'hA5; mem[1] = 8'h0F; mem[2] = 8'h80;
        regCtrlLimit = 1'b1; regMax = 13'd2;
        runFrame("basic", 1'b1, 1'b0, rises);
        checkValue("basic bitCount", rises, 24);

        // 32-bit padding skip
        foreach (mem[j]) mem[j] = 8'($urandom);
        regCtrl32bit = 1'b1; regMax = 13'd7;
        runFrame("skip32", 1'b1, 1'b0, rises);
`ifdef ANTON_SEQ_32BIT_EN
        checkValue("skip32 bitCount", rises, 48);
`else
        checkValue("skip32 bitCount", rises, 64);
`endif
        regCtrl32bit = 1'b0;

        // Loop: run held high as if reloaded from loop on every sync
        regMax = 13'd2;
        runFrame("loop0", 1'b1, 1'b1, rises);
        runFrame("loop1", 1'b0, 1'b1, rises);
        runFrame("loop2", 1'b0, 1'b0, rises);
        repeat (3) @(negedge busClk);
        checkValue("loop stopped", 32'(state), 0);

        // Abort in bit 5 of byte 1, with prefetch timing checked on the way
        foreach (mem[j]) mem[j] = 8'($urandom);
        regMax = 13'd5;
        regCtrlRun = 1'b1;
        @(negedge busClk);
        regCtrlRun = 1'b0;
        repeat (31) @(negedge busClk);
        checkValue("prefetch before", 32'(pixelAddr), 0);
        @(negedge busClk);
        checkValue("prefetch at bit3", 32'(pixelAddr), 1);
        repeat (50) @(negedge busClk);
        checkValue("abort preState", 32'(state), 1);
        regCtrlInit = 1'b1;
        regCtrlRun  = 1'b1;
        @(negedge busClk);
        checkValue("abort neoData", 32'(neoData), 0);
        checkValue("abort state", 32'(state), 0);
        checkValue("abort pixelAddr", 32'(pixelAddr), 0);
        bad = 0;
        repeat (40) begin
            @(negedge busClk);
            if (neoData !== 1'b0 || state !== 1'b0 || streamSyncOf !== 1'b0) bad++;
        end
        checkValue("abort held idle", bad, 0);
        regCtrlInit = 1'b0;
        regCtrlRun  = 1'b0;
        @(negedge busClk);
        runFrame("afterAbort", 1'b1, 1'b0, rises);

        // Reset pulse during the gap
        regMax = 13'd1;
        regCtrlRun = 1'b1;
        @(negedge busClk);
        regCtrlRun = 1'b0;
        repeat (2 * 8 * CPB + 100) @(negedge busClk);
        checkValue("gap preState", 32'(state), 1);
        #2 busRstN = 1'b0;
        #1;
        checkValue("async reset outs", 32'({state, neoData, streamSyncOf}), 0);
        checkValue("async reset addr", 32'(pixelAddr), 0);
        @(negedge busClk);
        busRstN = 1'b1;
        bad = 0;
        repeat (RST + 10) begin
            @(negedge busClk);
            if (streamSyncOf !== 1'b0 || state !== 1'b0) bad++;
        end
        checkValue("no sync after reset", bad, 0);
        runFrame("afterReset", 1'b1, 1'b0, rises);

        // Limit edges
        regMax = 13'h1FFF;
        runFrame("limitHigh", 1'b1, 1'b0, rises);
        checkValue("limitHigh bitCount", rises, 16 * 8);
        regMax = 13'd0;
        runFrame("limitZero", 1'b1, 1'b0, rises);
        checkValue("limitZero bitCount", rises, 8);

        // Randomised frames
        for (int k = 0; k < 8; k++) begin
            foreach (mem[j]) mem[j] = 8'($urandom);
            regCtrlLimit = 1'($urandom);
            regMax       = 13'($urandom_range(0, 20));
            if (k == 3) regMax = 13'h1FFF;
            regCtrl32bit = 1'($urandom);
            runFrame($sformatf("rand%0d", k), 1'b1, 1'b0, rises);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
